// File: rtl/pe_operand_gather_pkg.sv
// Shared definitions for the TABLA PE operand gather stage: function codes,
// operand source selects, FSM state encodings and the select range helper.
package pe_operand_gather_pkg;

    localparam logic [2:0] FN_PASS = 3'd0;
    localparam logic [2:0] FN_ADD  = 3'd1;
    localparam logic [2:0] FN_SUB  = 3'd2;
    localparam logic [2:0] FN_MUL  = 3'd3;
    localparam logic [2:0] FN_MAC  = 3'd4;
    localparam logic [2:0] FN_CMP  = 3'd5;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_NB   = 3'd1;
    localparam logic [2:0] SRC_GB   = 3'd2;
    localparam logic [2:0] SRC_IB   = 3'd3;
    localparam logic [2:0] SRC_WB   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_RESULT = 2'd3
    } gather_state_e;

    // Selects outside 1..n_src name no source and behave like SRC_NONE.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_src);
        return (sel != 32'd0) && (sel <= n_src);
    endfunction

endpackage

// File: rtl/pe_operand_gather_slot.sv
// One operand slot of the gather stage: holds the select, required and latched
// flags plus the captured word, and raises a pop request towards its source.
module pe_operand_slot
    import pe_operand_gather_pkg::*;
#(
    parameter int dataLen   = 32,
    parameter int numSrc    = 4,
    parameter int logNumSrc = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [logNumSrc-1:0]      i_sel,
    input  logic                      i_gather,
    input  logic [numSrc*dataLen-1:0] i_src_data,
    input  logic [numSrc-1:0]         i_pop,
    output logic [numSrc-1:0]         o_want,
    output logic                      o_ready,
    output logic                      o_req,
    output logic [dataLen-1:0]        o_data
);

    logic [logNumSrc-1:0] r_sel;
    logic                 r_req;
    logic                 r_lat;
    logic [dataLen-1:0]   r_data;
    logic [dataLen-1:0]   w_word;
    logic                 w_hit;

    // Decode the select into a one-hot pop request and route the matching word.
    always_comb begin
        o_want = '0;
        w_word = '0;
        for (int k = 0; k < numSrc; k++) begin
            if (r_sel == logNumSrc'(k + 1)) begin
                o_want[k] = i_gather && r_req && !r_lat;
                w_word    = i_src_data[k*dataLen +: dataLen];
            end else begin
                o_want[k] = 1'b0;
            end
        end
    end

    // A pop granted to any source this slot wants latches that word on this edge.
    assign w_hit   = |(o_want & i_pop);
    assign o_ready = !r_req || r_lat || w_hit;
    assign o_req   = r_req;
    assign o_data  = w_hit ? w_word : r_data;

    // Slot state: loaded on instruction accept, latched once per instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_req  <= 1'b0;
            r_lat  <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            if (sel_in_range(32'(i_sel), numSrc)) begin
                r_sel <= i_sel;
                r_req <= 1'b1;
            end else begin
                r_sel <= '0;
                r_req <= 1'b0;
            end
            r_lat  <= 1'b0;
            r_data <= '0;
        end else if (w_hit) begin
            r_lat  <= 1'b1;
            r_data <= w_word;
        end
    end

endmodule

// File: rtl/pe_operand_gather.sv
// Operand gather stage ahead of pe_compute: accepts an instruction, collects up to
// three operands from the PE sources, issues them and holds the result for writeback.
// Optional gather watchdog: define PE_GATHER_TIMEOUT_EN.
module pe_operand_gather
    import pe_operand_gather_pkg::*;
#(
    parameter int dataLen   = 32,
    parameter int logNumFn  = 3,
    parameter int numSrc    = 4,
    parameter int logNumSrc = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [logNumFn-1:0]       inst_fn,
    input  logic [logNumSrc-1:0]      inst_src1,
    input  logic [logNumSrc-1:0]      inst_src2,
    input  logic [logNumSrc-1:0]      inst_src3,
    input  logic [numSrc*dataLen-1:0] src_data,
    input  logic [numSrc-1:0]         src_valid,
    output logic [numSrc-1:0]         src_pop,
    output logic [dataLen-1:0]        operand1,
    output logic [dataLen-1:0]        operand2,
    output logic [dataLen-1:0]        operand3,
    output logic                      operand1_v,
    output logic                      operand2_v,
    output logic                      operand3_v,
    output logic                      operand1_req,
    output logic                      operand2_req,
    output logic                      operand3_req,
    output logic [logNumFn-1:0]       fn,
    input  logic [dataLen-1:0]        resultOut,
    input  logic                      done,
    output logic [dataLen-1:0]        result,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      err
);

    if (((2 ** logNumSrc) <= numSrc) || (TIMEOUT < 1)) begin : g_param_check
        $error("pe_operand_gather: select field too narrow or TIMEOUT below 1");
    end

    gather_state_e        r_state;
    logic                 r_inst_ready;
    logic [logNumFn-1:0]  r_fn;
    logic [dataLen-1:0]   r_op1;
    logic [dataLen-1:0]   r_op2;
    logic [dataLen-1:0]   r_op3;
    logic [2:0]           r_v;
    logic [2:0]           r_rq;
    logic [dataLen-1:0]   r_result;
    logic                 r_result_valid;

    logic                 w_accept;
    logic                 w_gather;
    logic                 w_any_req;
    logic                 w_all_rdy;
    logic                 w_timeout;
    logic [numSrc-1:0]    w_want1;
    logic [numSrc-1:0]    w_want2;
    logic [numSrc-1:0]    w_want3;
    logic                 w_rdy1;
    logic                 w_rdy2;
    logic                 w_rdy3;
    logic                 w_req1;
    logic                 w_req2;
    logic                 w_req3;
    logic [dataLen-1:0]   w_data1;
    logic [dataLen-1:0]   w_data2;
    logic [dataLen-1:0]   w_data3;

    assign w_accept  = inst_valid && r_inst_ready;
    assign w_gather  = (r_state == ST_GATHER);
    assign w_any_req = sel_in_range(32'(inst_src1), numSrc) ||
                       sel_in_range(32'(inst_src2), numSrc) ||
                       sel_in_range(32'(inst_src3), numSrc);

    pe_operand_slot #(.dataLen(dataLen), .numSrc(numSrc), .logNumSrc(logNumSrc)) u_slot1 (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_sel(inst_src1), .i_gather(w_gather),
        .i_src_data(src_data), .i_pop(src_pop), .o_want(w_want1), .o_ready(w_rdy1),
        .o_req(w_req1), .o_data(w_data1)
    );

    pe_operand_slot #(.dataLen(dataLen), .numSrc(numSrc), .logNumSrc(logNumSrc)) u_slot2 (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_sel(inst_src2), .i_gather(w_gather),
        .i_src_data(src_data), .i_pop(src_pop), .o_want(w_want2), .o_ready(w_rdy2),
        .o_req(w_req2), .o_data(w_data2)
    );

    pe_operand_slot #(.dataLen(dataLen), .numSrc(numSrc), .logNumSrc(logNumSrc)) u_slot3 (
        .clk(clk), .reset(reset), .i_load(w_accept), .i_sel(inst_src3), .i_gather(w_gather),
        .i_src_data(src_data), .i_pop(src_pop), .o_want(w_want3), .o_ready(w_rdy3),
        .o_req(w_req3), .o_data(w_data3)
    );

    // Slots sharing a source share its single pop.
    assign src_pop   = src_valid & (w_want1 | w_want2 | w_want3);
    assign w_all_rdy = w_rdy1 && w_rdy2 && w_rdy3;

`ifdef PE_GATHER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = w_gather && !w_all_rdy && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign err       = r_err;

    // Gather watchdog: counts GATHER cycles, err stays set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_gather && !w_all_rdy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Control FSM with registered handshake, operand and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_inst_ready   <= 1'b1;
            r_fn           <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_op3          <= '0;
            r_v            <= 3'b000;
            r_rq           <= 3'b000;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fn         <= inst_fn;
                        r_inst_ready <= 1'b0;
                        r_state      <= w_any_req ? ST_GATHER : ST_ISSUE;
                    end
                end
                ST_GATHER: begin
                    if (w_all_rdy) begin
                        r_op1   <= w_req1 ? w_data1 : '0;
                        r_op2   <= w_req2 ? w_data2 : '0;
                        r_op3   <= w_req3 ? w_data3 : '0;
                        r_v     <= {w_req3, w_req2, w_req1};
                        r_rq    <= {w_req3, w_req2, w_req1};
                        r_state <= ST_ISSUE;
                    end else if (w_timeout) begin
                        r_inst_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (done) begin
                        r_result       <= resultOut;
                        r_result_valid <= 1'b1;
                        r_op1          <= '0;
                        r_op2          <= '0;
                        r_op3          <= '0;
                        r_v            <= 3'b000;
                        r_rq           <= 3'b000;
                        r_state        <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_inst_ready   <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_inst_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_ready   = r_inst_ready;
    assign fn           = r_fn;
    assign operand1     = r_op1;
    assign operand2     = r_op2;
    assign operand3     = r_op3;
    assign operand1_v   = r_v[0];
    assign operand2_v   = r_v[1];
    assign operand3_v   = r_v[2];
    assign operand1_req = r_rq[0];
    assign operand2_req = r_rq[1];
    assign operand3_req = r_rq[2];
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_pe_operand_gather.sv
// Scoreboard bench for pe_operand_gather: stimulus pushes expected operand bundles
// and results, a negedge monitor pops and compares whenever the DUT presents them.
module tb_pe_operand_gather;
    import pe_operand_gather_pkg::*;

    localparam int DL = 32;
    localparam int NS = 4;
`ifdef PE_GATHER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    typedef struct {
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] o3;
        logic [2:0]  v;
        logic [2:0]  rq;
        logic [2:0]  fn;
    } iss_t;

    logic          clk;
    logic          reset;
    logic          inst_valid;
    logic          inst_ready;
    logic [2:0]    inst_fn;
    logic [2:0]    inst_src1;
    logic [2:0]    inst_src2;
    logic [2:0]    inst_src3;
    logic [127:0]  src_data;
    logic [3:0]    src_valid;
    logic [3:0]    src_pop;
    logic [31:0]   operand1;
    logic [31:0]   operand2;
    logic [31:0]   operand3;
    logic          operand1_v;
    logic          operand2_v;
    logic          operand3_v;
    logic          operand1_req;
    logic          operand2_req;
    logic          operand3_req;
    logic [2:0]    fn;
    logic [31:0]   resultOut;
    logic          done;
    logic [31:0]   result;
    logic          result_valid;
    logic          result_ready;
    logic          err;

    iss_t        iss_q[$];
    logic [31:0] res_q[$];
    iss_t        cur;
    bit          have_cur;
    bit          prev_v;
    bit          prev_rv;
    int          n_total;
    int          n_bad;
    int          n_issue;
    int          issue_cyc;
    int          rv_cyc;
    int          acc_cyc;
    int          cyc;
    int          pop_cnt[NS];
    int          pop_cyc[NS];

    pe_operand_gather #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_fn(inst_fn), .inst_src1(inst_src1), .inst_src2(inst_src2), .inst_src3(inst_src3),
        .src_data(src_data), .src_valid(src_valid), .src_pop(src_pop),
        .operand1(operand1), .operand2(operand2), .operand3(operand3),
        .operand1_v(operand1_v), .operand2_v(operand2_v), .operand3_v(operand3_v),
        .operand1_req(operand1_req), .operand2_req(operand2_req), .operand3_req(operand3_req),
        .fn(fn), .resultOut(resultOut), .done(done), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pops_vec();
        return {pop_cnt[3][7:0], pop_cnt[2][7:0], pop_cnt[1][7:0], pop_cnt[0][7:0]};
    endfunction

    // Monitor: count pops, compare operand bundles every ISSUE cycle and results on arrival.
    always @(negedge clk) begin
        if (reset) begin
            prev_v  = 1'b0;
            prev_rv = 1'b0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (src_pop[k]) begin
                    if (pop_cnt[k] == 0) pop_cyc[k] = cyc;
                    pop_cnt[k]++;
                end
            end
            if ((operand1_v || operand2_v || operand3_v) && !prev_v) begin
                if (iss_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    have_cur = 1'b0;
                    $display("FAIL issue_unexpected: act=issue exp=no_issue");
                end else begin
                    cur      = iss_q.pop_front();
                    have_cur = 1'b1;
                    n_issue++;
                    issue_cyc = cyc;
                end
            end
            if ((operand1_v || operand2_v || operand3_v) && have_cur)
                check("issue_bundle",
                      {operand1, operand2, operand3, operand3_v, operand2_v, operand1_v,
                       operand3_req, operand2_req, operand1_req, fn},
                      {cur.o1, cur.o2, cur.o3, cur.v, cur.rq, cur.fn});
            prev_v = operand1_v || operand2_v || operand3_v;
            if (result_valid && !prev_rv) begin
                if (res_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL result_unexpected: act=%0h exp=no_result", result);
                end else begin
                    check("result", result, res_q.pop_front());
                end
            end
            prev_rv = result_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pops();
        for (int k = 0; k < NS; k++) begin
            pop_cnt[k] = 0;
            pop_cyc[k] = -1;
        end
    endtask

    task automatic issue_inst(input logic [2:0] f, input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] s3);
        int i;
        i = 0;
        while (!inst_ready && i < 20) begin
            tick();
            i++;
        end
        check("inst_ready_wait", inst_ready, 1'b1);
        inst_fn    = f;
        inst_src1  = s1;
        inst_src2  = s2;
        inst_src3  = s3;
        inst_valid = 1'b1;
        acc_cyc    = cyc;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (!result_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        check(tag, result_valid, 1'b1);
        rv_cyc = cyc;
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [2:0] v, input logic [2:0] f, input logic [31:0] r);
        iss_t e;
        e.o1 = a; e.o2 = b; e.o3 = c; e.v = v; e.rq = v; e.fn = f;
        iss_q.push_back(e);
        res_q.push_back(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: act=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n_iss0;
        n_total = 0; n_bad = 0; n_issue = 0; have_cur = 1'b0;
        reset = 1'b1; inst_valid = 1'b0; inst_fn = 3'd0;
        inst_src1 = 3'd0; inst_src2 = 3'd0; inst_src3 = 3'd0;
        src_data = '0; src_valid = 4'b1111; resultOut = 32'd0; done = 1'b0; result_ready = 1'b0;
        clear_pops();
        repeat (2) @(negedge clk);
        check("rst_flags", {inst_ready, operand3_v, operand2_v, operand1_v, operand3_req,
                            operand2_req, operand1_req, fn, result_valid, err, src_pop}, 16'h8000);
        check("rst_data", {operand1, operand2, operand3, result}, 128'd0);
        tick();
        reset = 1'b0; src_valid = 4'b0000;

        // 1: two sources ready at once, done tied high
        clear_pops();
        src_data[0*DL +: DL] = 32'd5; src_data[1*DL +: DL] = 32'd9; src_valid = 4'b0011;
        done = 1'b1; resultOut = 32'd14;
        push_exp(32'd5, 32'd9, 32'd0, 3'b011, FN_ADD, 32'd14);
        issue_inst(FN_ADD, SRC_NB, SRC_GB, SRC_NONE);
        wait_result("t1_result_valid");
        check("t1_latency", 32'(rv_cyc - acc_cyc), 32'd3);
        release_result();
        src_valid = 4'b0000;
        check("t1_pops", pops_vec(), 32'h0000_0101);

        // 2: all three operands from one source, single pop
        clear_pops();
        src_data[2*DL +: DL] = 32'd7; src_valid = 4'b0100; resultOut = 32'd21;
        push_exp(32'd7, 32'd7, 32'd7, 3'b111, FN_MUL, 32'd21);
        issue_inst(FN_MUL, SRC_IB, SRC_IB, SRC_IB);
        wait_result("t2_result_valid");
        release_result();
        src_valid = 4'b0000;
        check("t2_pops", pops_vec(), 32'h0001_0000);

        // 3: operands arrive at cycles 1 and 6
        clear_pops();
        src_data[0*DL +: DL] = 32'hA0A0_0000; src_data[3*DL +: DL] = 32'h3333_3333;
        resultOut = 32'h1234_5678;
        push_exp(32'hA0A0_0000, 32'h3333_3333, 32'd0, 3'b011, FN_MAC, 32'h1234_5678);
        issue_inst(FN_MAC, SRC_NB, SRC_WB, SRC_NONE);
        src_valid = 4'b1000;
        tick();
        src_valid = 4'b0000; src_data[3*DL +: DL] = 32'hBAD0_0000;
        while (cyc < acc_cyc + 6) tick();
        src_valid = 4'b0001;
        tick();
        src_valid = 4'b0000;
        wait_result("t3_result_valid");
        check("t3_issue_cycle", 32'(issue_cyc - acc_cyc), 32'd7);
        check("t3_pop3_cycle", 32'(pop_cyc[3] - acc_cyc), 32'd1);
        release_result();
        check("t3_pops", pops_vec(), 32'h0100_0001);

        // 4: done held low five ISSUE cycles, result held while not accepted
        clear_pops();
        done = 1'b0; resultOut = 32'd0;
        src_data[0*DL +: DL] = 32'h0A0A_0A0A; src_data[1*DL +: DL] = 32'h0B0B_0B0B;
        src_data[2*DL +: DL] = 32'h0C0C_0C0C; src_valid = 4'b0111;
        push_exp(32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 3'b111, FN_SUB, 32'hDEAD_BEEF);
        issue_inst(FN_SUB, SRC_NB, SRC_GB, SRC_IB);
        tick();
        src_valid = 4'b0000;
        repeat (4) tick();
        @(negedge clk);
        check("t4_still_issue", {operand3_v, operand2_v, operand1_v, result_valid}, 4'b1110);
        tick();
        done = 1'b1; resultOut = 32'hDEAD_BEEF;
        tick();
        done = 1'b0; resultOut = 32'd0;
        wait_result("t4_result_valid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold", {result_valid, inst_ready, operand1_v}, 3'b100);
        end
        release_result();
        check("t4_pops", pops_vec(), 32'h0001_0101);

        // done pulse while idle is ignored
        done = 1'b1; resultOut = 32'hFFFF_FFFF;
        repeat (2) tick();
        @(negedge clk);
        check("idle_done_ignored", {result_valid, operand1_v, inst_ready}, 3'b001);
        done = 1'b0;

        // 5: reset while operand1 is latched, then a fresh instruction
        clear_pops();
        src_data[0*DL +: DL] = 32'h0000_0055;
        issue_inst(FN_ADD, SRC_NB, SRC_GB, SRC_NONE);
        src_valid = 4'b0001;
        tick();
        src_valid = 4'b0000;
        tick();
        @(negedge clk);
        check("t5_gathering", {inst_ready, operand1_v, pops_vec()}, {2'b00, 32'h0000_0001});
        #2;
        reset = 1'b1; src_valid = 4'b1111;
        #1;
        check("t5_rst_flags", {inst_ready, operand3_v, operand2_v, operand1_v, operand3_req,
                               operand2_req, operand1_req, fn, result_valid, err, src_pop}, 16'h8000);
        check("t5_rst_data", {operand1, operand2, operand3, result}, 128'd0);
        tick();
        tick();
        reset = 1'b0; src_valid = 4'b0000;
        clear_pops();
        src_data[0*DL +: DL] = 32'h0000_0011; src_data[1*DL +: DL] = 32'h0000_0022;
        src_valid = 4'b0011; done = 1'b1; resultOut = 32'h0000_0033;
        push_exp(32'h0000_0011, 32'h0000_0022, 32'd0, 3'b011, FN_SUB, 32'h0000_0033);
        issue_inst(FN_SUB, SRC_NB, SRC_GB, SRC_NONE);
        wait_result("t5_result_valid");
        release_result();
        src_valid = 4'b0000; done = 1'b0;
        check("t5_pops", pops_vec(), 32'h0000_0101);

        // 6: source that never becomes valid
        clear_pops();
        n_iss0 = n_issue;
        issue_inst(FN_ADD, SRC_GB, SRC_NONE, SRC_NONE);
`ifdef PE_GATHER_TIMEOUT_EN
        while (cyc < acc_cyc + 16) tick();
        @(negedge clk);
        check("t6_err_before", {err, inst_ready}, 2'b00);
        @(negedge clk);
        check("t6_err_set", {err, inst_ready}, 2'b11);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", err, 1'b1);
        tick();
`else
        repeat (20) tick();
        @(negedge clk);
        check("t6_wait", {err, inst_ready}, 2'b00);
        tick();
`endif
        check("t6_no_issue", 32'(n_issue - n_iss0), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_after_reset", {err, inst_ready}, 2'b01);

        check("iss_q_empty", 32'(iss_q.size()), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
